adc_strobe_pulse_gen: RTL

Converts a single-cycle trigger pulse into a timed level pulse of programmable delay and width, followed by a programmable hold-off. It is the generating end of the pulse/edge path in ADC_Timing: the sample-tick pulse enters here, and the output drives the ADC conversion-start (CONVST) strobe. Triggers that arrive while a strobe is in progress are counted as missed.

---
 rtl/adc_timing_pkg.sv | 33 +++
 rtl/load_down_counter.sv | 38 +++
 rtl/adc_strobe_pulse_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/adc_timing_pkg.sv
// -----------------------------------------------------------------------------
// adc_timing_pkg
// Shared types and constants for the ADC_Timing pulse/edge path.
//   pulse_state_t      : strobe FSM state encoding
//   CNT_W_DEFAULT      : default counter / miss-count width
//   MISS_SAT_DEFAULT   : saturation value of MISS_CNT at the default width
//   miss_sat()         : saturation value of MISS_CNT for an arbitrary width
// -----------------------------------------------------------------------------
package adc_timing_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    HIGH    = 2'd2,
    HOLDOFF = 2'd3
  } pulse_state_t;

  localparam int unsigned CNT_W_DEFAULT = 16;

  // Largest value MISS_CNT may hold before it sticks.
  localparam logic [CNT_W_DEFAULT-1:0] MISS_SAT_DEFAULT = {CNT_W_DEFAULT{1'b1}};

  // Saturation value for a width w (1..32), as a 32-bit quantity.
  function automatic logic [31:0] miss_sat(input int unsigned w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/load_down_counter.sv
// -----------------------------------------------------------------------------
// load_down_counter
// Loadable down-counter that stops at zero. Shared by every timed state of the
// strobe FSM: the FSM loads N-1 on entry to a state and leaves when ZERO is set.
// Ports:
//   CLK    : clock, rising edge
//   RST_N  : synchronous active-low reset (count -> 0)
//   LOAD   : load VALUE at the next edge (has priority over counting)
//   VALUE  : value to load
//   ZERO   : count is zero
// -----------------------------------------------------------------------------
module load_down_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] VALUE,
  output logic             ZERO
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (LOAD) begin
      r_count <= VALUE;
    end else if (r_count != '0) begin
      r_count <= r_count - ONE;
    end
  end

  assign ZERO = (r_count == '0);

endmodule

// File: rtl/adc_strobe_pulse_gen.sv
// -----------------------------------------------------------------------------
// adc_strobe_pulse_gen
// Turns a single-cycle trigger into a delayed, fixed-width CONVST strobe
// followed by a hold-off window. Triggers arriving while busy are counted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for TRIG with EN=1
// DELAY   | counting DELAY_CYC before the strobe asserts
// HIGH    | strobe asserted for WIDTH_CYC (min 1) cycles
// HOLDOFF | dead time of HOLDOFF_CYC cycles before re-arming
//
// Ports:
//   CLK, RST_N        : clock and synchronous active-low reset
//   EN, TRIG          : trigger enable and trigger pulse
//   DELAY_CYC         : trigger-to-strobe delay in cycles
//   WIDTH_CYC         : strobe width in cycles (0 acts as 1)
//   HOLDOFF_CYC       : dead cycles after the strobe
//   CLR_MISS          : clear MISS_CNT
//   PULSE             : strobe, polarity set by ACTIVE_HIGH, registered
//   BUSY              : FSM not idle, registered
//   DONE              : one cycle as the strobe deasserts
//   MISSED            : one cycle per rejected trigger
//   MISS_CNT          : saturating count of rejected triggers
// -----------------------------------------------------------------------------
module adc_strobe_pulse_gen
  import adc_timing_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter logic        ACTIVE_HIGH = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             TRIG,
  input  logic [CNT_W-1:0] DELAY_CYC,
  input  logic [CNT_W-1:0] WIDTH_CYC,
  input  logic [CNT_W-1:0] HOLDOFF_CYC,
  input  logic             CLR_MISS,
  output logic             PULSE,
  output logic             BUSY,
  output logic             DONE,
  output logic             MISSED,
  output logic [CNT_W-1:0] MISS_CNT
);

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MISS_SAT = {CNT_W{1'b1}};
  localparam logic             P_ON     = ACTIVE_HIGH;
  localparam logic             P_OFF    = ~ACTIVE_HIGH;

  pulse_state_t     r_state;
  logic [CNT_W-1:0] r_width_m1;
  logic [CNT_W-1:0] r_holdoff;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_missed;
  logic [CNT_W-1:0] r_miss_cnt;

  logic             w_zero;
  logic             w_load;
  logic [CNT_W-1:0] w_value;
  logic [CNT_W-1:0] w_width_in_m1;
  logic             w_finishing;
  logic             w_free;
  logic             w_accept;
  logic             w_miss;

  assign w_width_in_m1 = (WIDTH_CYC == '0) ? '0 : (WIDTH_CYC - ONE);

  // The edge that returns the FSM to IDLE is already free for a new trigger,
  // so the next strobe can start exactly D+W+H edges after the previous one
  // (back-to-back strobes when D=0, W<=1, H=0).
  assign w_finishing = ((r_state == HIGH)    && w_zero && (r_holdoff == '0)) ||
                       ((r_state == HOLDOFF) && w_zero);
  assign w_free      = (r_state == IDLE) || w_finishing;
  assign w_accept    = w_free && EN && TRIG;
  assign w_miss      = !w_free && TRIG;

  always_comb begin
    w_load  = 1'b0;
    w_value = '0;
    if (w_accept) begin
      w_load  = 1'b1;
      w_value = (DELAY_CYC == '0) ? w_width_in_m1 : (DELAY_CYC - ONE);
    end else begin
      case (r_state)
        DELAY: begin
          if (w_zero) begin
            w_load  = 1'b1;
            w_value = r_width_m1;
          end
        end
        HIGH: begin
          if (w_zero && (r_holdoff != '0)) begin
            w_load  = 1'b1;
            w_value = r_holdoff - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  load_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .LOAD  (w_load),
    .VALUE (w_value),
    .ZERO  (w_zero)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_width_m1 <= '0;
      r_holdoff  <= '0;
      r_pulse    <= P_OFF;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_missed <= w_miss;
      r_done   <= (r_state == HIGH) && w_zero;
      if (w_accept) begin
        r_width_m1 <= w_width_in_m1;
        r_holdoff  <= HOLDOFF_CYC;
        r_busy     <= 1'b1;
        if (DELAY_CYC == '0) begin
          r_state <= HIGH;
          r_pulse <= P_ON;
        end else begin
          r_state <= DELAY;
          r_pulse <= P_OFF;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_pulse <= P_OFF;
            r_busy  <= 1'b0;
          end
          DELAY: begin
            if (w_zero) begin
              r_state <= HIGH;
              r_pulse <= P_ON;
            end
          end
          HIGH: begin
            if (w_zero) begin
              r_pulse <= P_OFF;
              if (r_holdoff != '0) begin
                r_state <= HOLDOFF;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          HOLDOFF: begin
            if (w_zero) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_pulse <= P_OFF;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A miss coinciding with a clear counts as the first miss after the clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_miss_cnt <= '0;
    end else if (w_miss) begin
      if (CLR_MISS) begin
        r_miss_cnt <= ONE;
      end else if (r_miss_cnt != MISS_SAT) begin
        r_miss_cnt <= r_miss_cnt + ONE;
      end
    end else if (CLR_MISS) begin
      r_miss_cnt <= '0;
    end
  end

  assign PULSE    = r_pulse;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign MISSED   = r_missed;
  assign MISS_CNT = r_miss_cnt;

endmodule
